march_job_scheduler: RTL and testbench

- Sequences one frame of ray marching: hands pixel jobs (hcount, vcount) in raster order to NUM_CORES ray-marcher cores.
- Arbitrates the cores' finished results onto the single framebuffer BRAM write port.
- Sits in top_level_main between the camera/frame trigger logic and the marcher cores / VGA framebuffer.

---
 rtl/march_job_scheduler_pkg.sv | 27 ++
 rtl/march_job_scheduler_rr_arbiter.sv | 41 ++++
 rtl/march_job_scheduler.sv | 145 ++++++++++++++
 tb/tb_march_job_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/march_job_scheduler_pkg.sv
// Shared types and frame defaults for the ray-march job scheduler.
package march_job_scheduler_pkg;

  localparam int FB_H_RES = 320;
  localparam int FB_V_RES = 240;
  localparam int COLOR_W  = 12;
  localparam int FB_H_W   = 9;
  localparam int FB_V_W   = 8;

  typedef struct packed {
    logic [FB_H_W-1:0] hcount;
    logic [FB_V_W-1:0] vcount;
  } pixel_job_t;

  typedef struct packed {
    logic [FB_H_W-1:0]  hcount;
    logic [FB_V_W-1:0]  vcount;
    logic [COLOR_W-1:0] color;
  } pixel_result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN
  } sched_state_e;

endpackage

// File: rtl/march_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; on advance the pointer moves just past the granted index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d, gidx, idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    gidx    = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        grant_o[idx]  = 1'b1;
        gidx          = idx;
      end
    end
    ptr_d = ptr_q;
    if (advance_i && found)
      ptr_d = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/march_job_scheduler.sv
// Frame sequencer: issues raster-order pixel jobs to the marcher cores and
// funnels their results, one per cycle, onto the framebuffer write port.
module march_job_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int H_RES     = march_job_scheduler_pkg::FB_H_RES,
  parameter int V_RES     = march_job_scheduler_pkg::FB_V_RES,
  parameter int H_W       = 9,
  parameter int V_W       = 8,
  parameter int COLOR_W   = march_job_scheduler_pkg::COLOR_W,
  parameter int ADDR_W    = 17
) (
  input  logic                           clk_100mhz,
  input  logic                           rst_n,
  input  logic                           frame_start,
  output logic                           busy,
  output logic                           frame_done,
  output logic [NUM_CORES-1:0]           job_valid,
  input  logic [NUM_CORES-1:0]           job_ready,
  output logic [H_W-1:0]                 job_hcount,
  output logic [V_W-1:0]                 job_vcount,
  input  logic [NUM_CORES-1:0]           res_valid,
  output logic [NUM_CORES-1:0]           res_ready,
  input  logic [NUM_CORES*H_W-1:0]       res_hcount,
  input  logic [NUM_CORES*V_W-1:0]       res_vcount,
  input  logic [NUM_CORES*COLOR_W-1:0]   res_color,
  output logic                           fb_we,
  output logic [ADDR_W-1:0]              fb_addr,
  output logic [COLOR_W-1:0]             fb_din
);
  import march_job_scheduler_pkg::*;

  localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(H_RES * V_RES);

  sched_state_e        state_q;
  logic [H_W-1:0]      h_q;
  logic [V_W-1:0]      v_q;
  logic [ADDR_W:0]     written_q, written_d;
  logic                busy_q, done_q, fb_we_q;
  logic [ADDR_W-1:0]   fb_addr_q;
  logic [COLOR_W-1:0]  fb_din_q;

  logic                dispatching, active, job_hs, res_hs, last_job;
  logic [H_W-1:0]      sel_h;
  logic [V_W-1:0]      sel_v;
  logic [COLOR_W-1:0]  sel_c;

  assign dispatching = (state_q == ST_DISPATCH);
  assign active      = (state_q != ST_IDLE);

  rr_arbiter #(.N(NUM_CORES)) u_job_arb (
    .clk       (clk_100mhz),
    .rst_n     (rst_n),
    .req_i     (job_ready & {NUM_CORES{dispatching}}),
    .advance_i (dispatching),
    .grant_o   (job_valid)
  );

  // Results are only taken while a frame is live; stale ones after a reset wait.
  rr_arbiter #(.N(NUM_CORES)) u_res_arb (
    .clk       (clk_100mhz),
    .rst_n     (rst_n),
    .req_i     (res_valid & {NUM_CORES{active}}),
    .advance_i (active),
    .grant_o   (res_ready)
  );

  assign job_hs   = |job_valid;
  assign res_hs   = |res_ready;
  assign last_job = (h_q == H_W'(H_RES - 1)) && (v_q == V_W'(V_RES - 1));

  always_comb begin
    sel_h = '0;
    sel_v = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (res_ready[i]) begin
        sel_h = sel_h | res_hcount[i*H_W +: H_W];
        sel_v = sel_v | res_vcount[i*V_W +: V_W];
        sel_c = sel_c | res_color[i*COLOR_W +: COLOR_W];
      end
    end
    written_d = written_q + {{ADDR_W{1'b0}}, fb_we_q};
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      written_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_din_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      fb_we_q   <= res_hs;
      fb_addr_q <= ADDR_W'(sel_v) * ADDR_W'(H_RES) + ADDR_W'(sel_h);
      fb_din_q  <= sel_c;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q   <= ST_DISPATCH;
            busy_q    <= 1'b1;
            h_q       <= '0;
            v_q       <= '0;
            written_q <= '0;
          end
        end
        ST_DISPATCH, ST_DRAIN: begin
          written_q <= written_d;
          if (dispatching && job_hs) begin
            if (last_job) begin
              h_q     <= '0;
              v_q     <= '0;
              state_q <= ST_DRAIN;
            end else if (h_q == H_W'(H_RES - 1)) begin
              h_q <= '0;
              v_q <= v_q + V_W'(1);
            end else begin
              h_q <= h_q + H_W'(1);
            end
          end
          // Completion overrides the DRAIN transition above.
          if (written_d == NPIX) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign job_hcount = h_q;
  assign job_vcount = v_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_din     = fb_din_q;

endmodule

// File: tb/tb_march_job_scheduler.sv
// Bench for march_job_scheduler on a 4x2 frame with two modelled marcher cores.
module tb_march_job_scheduler;

  localparam int NC = 2, HRES = 4, VRES = 2, HW = 3, VW = 2, CW = 12, AW = 4;

  logic              clk, rst_n, frame_start, busy, frame_done, fb_we;
  logic [NC-1:0]     job_valid, job_ready, res_valid, res_ready;
  logic [HW-1:0]     job_hcount;
  logic [VW-1:0]     job_vcount;
  logic [NC*HW-1:0]  res_hcount;
  logic [NC*VW-1:0]  res_vcount;
  logic [NC*CW-1:0]  res_color;
  logic [AW-1:0]     fb_addr;
  logic [CW-1:0]     fb_din;

  march_job_scheduler #(.NUM_CORES(NC), .H_RES(HRES), .V_RES(VRES), .H_W(HW),
                        .V_W(VW), .COLOR_W(CW), .ADDR_W(AW)) dut (
    .clk_100mhz(clk), .rst_n(rst_n), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .job_valid(job_valid), .job_ready(job_ready),
    .job_hcount(job_hcount), .job_vcount(job_vcount), .res_valid(res_valid),
    .res_ready(res_ready), .res_hcount(res_hcount), .res_vcount(res_vcount),
    .res_color(res_color), .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int h; int v; int due; } job_t;
  typedef struct { int addr; int din; } wr_t;
  typedef struct { int h; int v; } pos_t;

  job_t cq0[$], cq1[$];
  wr_t  sb[$];
  pos_t jq[$];
  int   job_core[$], rgrant_seq[$];

  int total, bad, cyc_n;
  int njobs, nwrites, ndone, first_wr_cyc, last_wr_cyc, done_cyc;
  int abc_acc_cyc, abc_wr_cyc, abc_addr, lat;
  bit done_busy, hold_en, release_auto, fs_req;
  logic [1:0] ready_en;

  function automatic int colf(input int h, input int v);
    if (h == 3 && v == 1) return 'hABC;
    return (h * 37 + v * 101 + 5) & 'hFFF;
  endfunction

  always @(posedge clk)
    for (int c = 0; c < NC; c++)
      if (rst_n && res_valid[c] && res_ready[c])
        assert (int'(res_hcount[c*HW +: HW]) < HRES && int'(res_vcount[c*VW +: VW]) < VRES)
          else $error("out-of-range result coordinate from core %0d", c);

  task automatic init_frame();
    jq.delete(); sb.delete(); job_core.delete(); rgrant_seq.delete();
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++) begin pos_t p; p.h = h; p.v = v; jq.push_back(p); end
    njobs = 0; nwrites = 0; ndone = 0; first_wr_cyc = -1; last_wr_cyc = -1;
    done_cyc = -1; done_busy = 1'b1; abc_acc_cyc = -1; abc_wr_cyc = -1; abc_addr = -1;
  endtask

  // One clock: drive core model at negedge, observe #1 later, update model/scoreboard.
  task automatic cyc();
    job_t hd; wr_t w; pos_t p; bit have; int t;
    @(negedge clk);
    cyc_n++;
    if (release_auto && njobs == HRES * VRES) hold_en = 1'b1;
    job_ready = ready_en; frame_start = fs_req; fs_req = 1'b0;
    res_valid = '0;
    for (int c = 0; c < NC; c++) begin
      have = 1'b0;
      if (c == 0 && cq0.size() > 0) begin hd = cq0[0]; have = 1'b1; end
      if (c == 1 && cq1.size() > 0) begin hd = cq1[0]; have = 1'b1; end
      if (have && hold_en && hd.due <= cyc_n) begin
        res_valid[c] = 1'b1;
        res_hcount[c*HW +: HW] = hd.h[HW-1:0];
        res_vcount[c*VW +: VW] = hd.v[VW-1:0];
        t = colf(hd.h, hd.v);
        res_color[c*CW +: CW] = t[CW-1:0];
      end
    end
    #1;
    total++;
    if (sb.size() > 0) begin
      w = sb.pop_front();
      if (fb_we !== 1'b1 || int'(fb_addr) != w.addr || int'(fb_din) != w.din) begin
        bad++;
        $display("FAIL fb_write cyc=%0d got we=%b addr=%0d din=%h want we=1 addr=%0d din=%h",
                 cyc_n, fb_we, fb_addr, fb_din, w.addr, w.din);
      end
    end else if (fb_we !== 1'b0) begin
      bad++; $display("FAIL fb_spurious cyc=%0d got we=%b want 0", cyc_n, fb_we);
    end
    if (fb_we === 1'b1) begin
      nwrites++; last_wr_cyc = cyc_n;
      if (first_wr_cyc < 0) first_wr_cyc = cyc_n;
      if (fb_din === 12'hABC) begin abc_addr = int'(fb_addr); abc_wr_cyc = cyc_n; end
    end
    if (frame_done === 1'b1) begin ndone++; done_cyc = cyc_n; done_busy = busy; end
    total++;
    if ($countones(job_valid) > 1 || $countones(res_ready) > 1 || (res_ready & ~res_valid) != 0) begin
      bad++; $display("FAIL onehot cyc=%0d got job_valid=%b res_ready=%b res_valid=%b",
                      cyc_n, job_valid, res_ready, res_valid);
    end
    for (int c = 0; c < NC; c++) begin
      if (job_valid[c] && job_ready[c]) begin
        total++;
        if (jq.size() == 0) begin
          bad++; $display("FAIL job_extra cyc=%0d got job (%0d,%0d) core %0d want none",
                          cyc_n, job_hcount, job_vcount, c);
        end else begin
          p = jq.pop_front();
          if (int'(job_hcount) != p.h || int'(job_vcount) != p.v) begin
            bad++; $display("FAIL job_pos cyc=%0d got (%0d,%0d) want (%0d,%0d)",
                            cyc_n, job_hcount, job_vcount, p.h, p.v);
          end
          hd.h = p.h; hd.v = p.v; hd.due = cyc_n + lat;
          if (c == 0) cq0.push_back(hd); else cq1.push_back(hd);
          job_core.push_back(c); njobs++;
        end
      end
      if (res_ready[c] && res_valid[c]) begin
        if (c == 0) hd = cq0.pop_front(); else hd = cq1.pop_front();
        w.addr = hd.v * HRES + hd.h; w.din = colf(hd.h, hd.v);
        sb.push_back(w); rgrant_seq.push_back(c);
        if (c == 1 && hd.h == 3 && hd.v == 1) abc_acc_cyc = cyc_n;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (ndone == 0 && n < budget) begin cyc(); n++; end
    total++;
    if (ndone == 0) begin bad++; $display("FAIL frame_timeout got no frame_done in %0d cycles", budget); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    job_ready = 2'b11; res_valid = 2'b11; frame_start = 1'b1;
    #1;
    total++;
    if ({busy, frame_done, job_valid, res_ready, fb_we} !== 7'b0 || job_hcount !== '0 ||
        job_vcount !== '0 || fb_addr !== '0 || fb_din !== '0) begin
      bad++; $display("FAIL reset_outputs got busy=%b done=%b jv=%b rr=%b we=%b h=%0d v=%0d addr=%0d din=%h want all 0",
                      busy, frame_done, job_valid, res_ready, fb_we, job_hcount, job_vcount, fb_addr, fb_din);
    end
    @(negedge clk);
    frame_start = 1'b0; res_valid = '0; rst_n = 1'b1;
    repeat (20) begin
      cyc();
      total++;
      if (busy !== 1'b0 || job_valid !== '0 || fb_we !== 1'b0) begin
        bad++; $display("FAIL idle_quiet cyc=%0d got busy=%b jv=%b we=%b want 0", cyc_n, busy, job_valid, fb_we);
      end
    end
  endtask

  task automatic test_raster();
    int errs = 0;
    init_frame(); lat = 3; hold_en = 1'b1; ready_en = 2'b11;
    fs_req = 1'b1; cyc(); cyc();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise got %b want 1", busy); end
    wait_done(200);
    repeat (4) cyc();
    for (int i = 0; i < job_core.size(); i++) if (job_core[i] != i % 2) errs++;
    total++;
    if (njobs != 8 || errs != 0) begin
      bad++; $display("FAIL raster_rr got jobs=%0d core_errs=%0d want jobs=8 core_errs=0", njobs, errs);
    end
    total++;
    if (nwrites != 8 || ndone != 1 || done_cyc != last_wr_cyc + 1 || done_busy !== 1'b0) begin
      bad++; $display("FAIL raster_done got writes=%0d dones=%0d done_cyc=%0d last_wr=%0d busy=%b want 8,1,last+1,0",
                      nwrites, ndone, done_cyc, last_wr_cyc, done_busy);
    end
  endtask

  task automatic test_addr();
    init_frame(); lat = 1; hold_en = 1'b1; ready_en = 2'b11;
    fs_req = 1'b1;
    wait_done(200);
    repeat (2) cyc();
    total++;
    if (abc_acc_cyc < 0 || abc_addr != 7 || abc_wr_cyc != abc_acc_cyc + 1) begin
      bad++; $display("FAIL addr_latency got acc_cyc=%0d wr_cyc=%0d addr=%0d want core1 accept, wr=acc+1, addr=7",
                      abc_acc_cyc, abc_wr_cyc, abc_addr);
    end
  endtask

  task automatic test_contention();
    int same = 0;
    init_frame(); lat = 3; hold_en = 1'b0; release_auto = 1'b1; ready_en = 2'b11;
    fs_req = 1'b1;
    wait_done(200);
    release_auto = 1'b0; hold_en = 1'b1;
    repeat (2) cyc();
    for (int i = 1; i < rgrant_seq.size(); i++) if (rgrant_seq[i] == rgrant_seq[i-1]) same++;
    total++;
    if (rgrant_seq.size() != 8 || same != 0 || last_wr_cyc - first_wr_cyc != 7) begin
      bad++; $display("FAIL contention got grants=%0d repeats=%0d write_span=%0d want 8,0,7",
                      rgrant_seq.size(), same, last_wr_cyc - first_wr_cyc);
    end
    total++;
    if (nwrites != 8 || ndone != 1 || done_cyc != last_wr_cyc + 1 || done_busy !== 1'b0) begin
      bad++; $display("FAIL contention_done got writes=%0d dones=%0d done_cyc=%0d last_wr=%0d busy=%b want 8,1,last+1,0",
                      nwrites, ndone, done_cyc, last_wr_cyc, done_busy);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    init_frame(); lat = 2; hold_en = 1'b1; ready_en = 2'b11;
    fs_req = 1'b1;
    while (njobs < 3 && n < 50) begin cyc(); n++; end
    ready_en = 2'b00;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) fs_req = 1'b1;
      cyc();
      total++;
      if (job_valid !== '0 || job_hcount !== 3'd3 || job_vcount !== 2'd0) begin
        bad++; $display("FAIL backpressure_hold cyc=%0d got jv=%b pos=(%0d,%0d) want 0,(3,0)",
                        cyc_n, job_valid, job_hcount, job_vcount);
      end
    end
    ready_en = 2'b11;
    wait_done(200);
    repeat (3) cyc();
    total++;
    if (njobs != 8 || nwrites != 8 || ndone != 1) begin
      bad++; $display("FAIL backpressure_frame got jobs=%0d writes=%0d dones=%0d want 8,8,1", njobs, nwrites, ndone);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    init_frame(); lat = 3; hold_en = 1'b1; ready_en = 2'b11;
    fs_req = 1'b1;
    while (nwrites < 3 && n < 100) begin cyc(); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || fb_we !== 1'b0 || job_valid !== '0 ||
        res_ready !== '0 || job_hcount !== '0 || job_vcount !== '0) begin
      bad++; $display("FAIL reset_mid got busy=%b done=%b we=%b jv=%b rr=%b pos=(%0d,%0d) want all 0",
                      busy, frame_done, fb_we, job_valid, res_ready, job_hcount, job_vcount);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      cyc();
      total++;
      if (res_ready !== '0 || fb_we !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL stale_results cyc=%0d got rr=%b we=%b busy=%b want 0 (res_valid=%b)",
                        cyc_n, res_ready, fb_we, busy, res_valid);
      end
    end
    cq0.delete(); cq1.delete();
    init_frame();
    fs_req = 1'b1;
    wait_done(200);
    repeat (3) cyc();
    total++;
    if (nwrites != 8 || ndone != 1 || njobs != 8) begin
      bad++; $display("FAIL reset_recover got writes=%0d dones=%0d jobs=%0d want 8,1,8", nwrites, ndone, njobs);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc_n = 0;
    rst_n = 1'b0; frame_start = 1'b0; job_ready = '0; res_valid = '0;
    res_hcount = '0; res_vcount = '0; res_color = '0;
    ready_en = 2'b11; hold_en = 1'b1; release_auto = 1'b0; fs_req = 1'b0; lat = 3;
    init_frame();
    test_reset();
    test_raster();
    test_addr();
    test_contention();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
